loop_stack: RTL and testbench
=============================

LOOP_STACK -- requirements
Module: loop_stack

Interface
REQ-001 Parameter WIDTH_ADDR, default 8, SHALL set the width of the stored loop-start program address.
REQ-002 Parameter N_ENTRIES, default 16, SHALL set the stack depth and SHALL be a power of two, at least 2.
REQ-003 Parameter SKIP_DEPTH_W, default 8, SHALL set the width of the forward-skip nesting counter.
REQ-004 Ports SHALL be, clock and reset first:
- clk_in  in  1  sole clock; all state changes on its rising edge.
- reset_in  in  1  asynchronous, active-low reset.
- push_in  in  1  push data_in; single-cycle command.
- pop_in  in  1  pop top entry; single-cycle command.
- data_in  in  WIDTH_ADDR  address to push.
- data_out  out  WIDTH_ADDR  current top entry, registered.
- count_out  out  $clog2(N_ENTRIES)+1  number of valid entries.
- empty_out  out  1  count_out==0.
- full_out  out  1  count_out==N_ENTRIES.
- skip_start_in  in  1  enter forward-skip mode ('[' with zero cell).
- open_in  in  1  '[' decoded while skipping.
- close_in  in  1  ']' decoded while skipping.
- skipping_out  out  1  high while in SKIP state.
- skip_done_out  out  1  one-cycle pulse when the matching ']' is found.
- clear_err_in  in  1  clear sticky error flags.
- overflow_out  out  1  sticky: push to full stack, or skip counter overflow.
- underflow_out  out  1  sticky: pop from empty stack.

Function
REQ-005 The FSM SHALL have two states: IDLE and SKIP.
REQ-006 In IDLE, push_in alone with count<N_ENTRIES SHALL store data_in at slot count and increment count; data_out SHALL equal data_in on the following cycle.
REQ-007 In IDLE, pop_in alone with count>0 SHALL decrement count; data_out SHALL show the new top on the following cycle, or 0 if the stack becomes empty.
REQ-008 In IDLE, push_in and pop_in together with count>0 SHALL replace the top with data_in and leave count unchanged. This also applies when full, and SHALL raise no error.
REQ-009 In IDLE, push_in and pop_in together with count==0 SHALL act as push only: count becomes 1 and no underflow is raised.
REQ-010 A push_in alone when full SHALL leave storage and count unchanged and SHALL set overflow_out.
REQ-011 A pop_in alone when empty SHALL leave state unchanged and SHALL set underflow_out.
REQ-012 skip_start_in in IDLE SHALL move to SKIP next cycle with the skip counter at 0. It SHALL take priority over push/pop in the same cycle, and push/pop SHALL be ignored that cycle.
REQ-013 In SKIP:
- push_in, pop_in and skip_start_in SHALL be ignored and SHALL raise no errors.
- Stack contents and count SHALL be preserved.
REQ-014 In SKIP, open_in alone SHALL increment the skip counter. At the all-ones value the counter SHALL saturate and set overflow_out.
REQ-015 In SKIP, close_in alone with counter>0 SHALL decrement the counter.
REQ-016 In SKIP, close_in alone with counter==0 SHALL return to IDLE and pulse skip_done_out for exactly that cycle's successor (one cycle).
REQ-017 In SKIP, open_in and close_in together SHALL leave the counter unchanged and SHALL not exit SKIP.
REQ-018 open_in and close_in SHALL be ignored in IDLE.
REQ-019 skipping_out SHALL be high exactly while the state is SKIP.
REQ-020 Sticky error flags SHALL clear on clear_err_in. A new error event in the same cycle SHALL win, and the flag SHALL remain set.
REQ-021 empty_out, full_out and count_out SHALL be registered-consistent: all three SHALL reflect the same post-edge count.

Reset
REQ-022 Asserting reset_in low SHALL, asynchronously and at any time including mid-SKIP:
- set the state to IDLE;
- set count_out, data_out and the skip counter to 0;
- set empty_out to 1;
- set full_out, skipping_out, skip_done_out, overflow_out and underflow_out to 0.
REQ-023 Storage array contents need not be cleared by reset; data_out SHALL still read 0 while empty.
REQ-024 The first command SHALL be accepted on the first rising edge after reset_in deasserts.

Verification
REQ-025 The bench SHALL cover these directed scenarios:
- Push 0x10, 0x20, 0x30 -> count 3; data_out 0x30. Pop -> data_out 0x20, count 2.
- N_ENTRIES=16: push 16 values, then push 0xAA -> full_out 1; overflow_out 1; count 16; top unchanged. Push+pop 0x55 -> top 0x55, no further change to flags.
- Empty: pop -> underflow_out 1. Push+pop 0x07 -> count 1, data_out 0x07. clear_err_in -> both flags 0.
- skip_start, then open, open, close, close, close -> skipping_out high for 5 cycles; skip_done_out pulses once after the third close; stack contents unchanged.
- SKIP with push_in/pop_in asserted every cycle -> count and data_out constant; no error flags.
- Reset low mid-SKIP with count 3 -> immediately IDLE, count 0, empty_out 1, skipping_out 0, data_out 0.

Source files
------------

// File: rtl/loop_stack.sv
// Loop-address stack for a bracket-matching interpreter: holds loop-start addresses
// and tracks nesting depth while skipping forward over a loop body whose cell is zero.
module loop_stack #(
    parameter int WIDTH_ADDR   = 8,
    parameter int N_ENTRIES    = 16,
    parameter int SKIP_DEPTH_W = 8
) (
    input  logic                           clk_in,
    input  logic                           reset_in,
    input  logic                           push_in,
    input  logic                           pop_in,
    input  logic [WIDTH_ADDR-1:0]          data_in,
    output logic [WIDTH_ADDR-1:0]          data_out,
    output logic [$clog2(N_ENTRIES):0]     count_out,
    output logic                           empty_out,
    output logic                           full_out,
    input  logic                           skip_start_in,
    input  logic                           open_in,
    input  logic                           close_in,
    output logic                           skipping_out,
    output logic                           skip_done_out,
    input  logic                           clear_err_in,
    output logic                           overflow_out,
    output logic                           underflow_out
);

    localparam int PTR_W = $clog2(N_ENTRIES);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {IDLE = 1'b0, SKIP = 1'b1} state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic [WIDTH_ADDR-1:0]   data_q, data_d;
    logic [SKIP_DEPTH_W-1:0] skip_q, skip_d;
    logic                    done_q, done_d;
    logic                    ovf_q, ovf_d;
    logic                    unf_q, unf_d;

    logic [WIDTH_ADDR-1:0]   mem [N_ENTRIES];
    logic                    wr_en;
    logic [PTR_W-1:0]        wr_addr;
    logic                    ovf_ev, unf_ev;
    logic                    is_full, is_empty;
    logic [CNT_W-1:0]        cnt_m1, cnt_m2;

    assign is_full  = (count_q == CNT_W'(N_ENTRIES));
    assign is_empty = (count_q == '0);
    assign cnt_m1   = count_q - CNT_W'(1);
    assign cnt_m2   = count_q - CNT_W'(2);

    // State register
    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) state_q <= IDLE;
        else           state_q <= state_d;
    end

    // Next-state logic: a lone ']' at depth zero closes the skipped loop
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (skip_start_in) state_d = SKIP;
            SKIP: if (close_in && !open_in && skip_q == '0) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        skipping_out = (state_q == SKIP);
    end

    always_comb begin
        count_d = count_q;
        data_d  = data_q;
        skip_d  = skip_q;
        done_d  = 1'b0;
        wr_en   = 1'b0;
        wr_addr = '0;
        ovf_ev  = 1'b0;
        unf_ev  = 1'b0;
        if (state_q == IDLE) begin
            if (skip_start_in) begin
                skip_d = '0;
            end else if (push_in && pop_in) begin
                // Replace-top; on an empty stack this degenerates to a plain push
                wr_en  = 1'b1;
                data_d = data_in;
                if (is_empty) begin
                    wr_addr = '0;
                    count_d = CNT_W'(1);
                end else begin
                    wr_addr = cnt_m1[PTR_W-1:0];
                end
            end else if (push_in) begin
                if (is_full) begin
                    ovf_ev = 1'b1;
                end else begin
                    wr_en   = 1'b1;
                    wr_addr = count_q[PTR_W-1:0];
                    count_d = count_q + CNT_W'(1);
                    data_d  = data_in;
                end
            end else if (pop_in) begin
                if (is_empty) begin
                    unf_ev = 1'b1;
                end else begin
                    count_d = cnt_m1;
                    data_d  = (count_q > CNT_W'(1)) ? mem[cnt_m2[PTR_W-1:0]] : '0;
                end
            end
        end else begin
            if (open_in && !close_in) begin
                if (&skip_q) ovf_ev = 1'b1;
                else         skip_d = skip_q + SKIP_DEPTH_W'(1);
            end else if (close_in && !open_in) begin
                if (skip_q != '0) skip_d = skip_q - SKIP_DEPTH_W'(1);
                else              done_d = 1'b1;
            end
        end
        // A fresh error in the clearing cycle keeps its flag set
        ovf_d = (ovf_q && !clear_err_in) || ovf_ev;
        unf_d = (unf_q && !clear_err_in) || unf_ev;
    end

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            count_q <= '0;
            data_q  <= '0;
            skip_q  <= '0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            data_q  <= data_d;
            skip_q  <= skip_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Storage is deliberately not reset; data_q masks stale contents when empty
    always_ff @(posedge clk_in) begin
        if (wr_en) mem[wr_addr] <= data_in;
    end

    assign data_out      = data_q;
    assign count_out     = count_q;
    assign empty_out     = is_empty;
    assign full_out      = is_full;
    assign skip_done_out = done_q;
    assign overflow_out  = ovf_q;
    assign underflow_out = unf_q;

endmodule

// File: tb/tb_loop_stack.sv
// Directed bench for loop_stack: stack push/pop/replace, error flags, skip nesting and reset.
module tb_loop_stack;

    logic       clk;
    logic       reset_in;
    logic       push_in, pop_in, skip_start_in, open_in, close_in, clear_err_in;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic [4:0] count_out;
    logic       empty_out, full_out, skipping_out, skip_done_out;
    logic       overflow_out, underflow_out;

    int checks   = 0;
    int failures = 0;

    loop_stack #(.WIDTH_ADDR(8), .N_ENTRIES(16), .SKIP_DEPTH_W(8)) dut (
        .clk_in        (clk),
        .reset_in      (reset_in),
        .push_in       (push_in),
        .pop_in        (pop_in),
        .data_in       (data_in),
        .data_out      (data_out),
        .count_out     (count_out),
        .empty_out     (empty_out),
        .full_out      (full_out),
        .skip_start_in (skip_start_in),
        .open_in       (open_in),
        .close_in      (close_in),
        .skipping_out  (skipping_out),
        .skip_done_out (skip_done_out),
        .clear_err_in  (clear_err_in),
        .overflow_out  (overflow_out),
        .underflow_out (underflow_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock of command inputs; returns 1 time unit after the edge with inputs idle
    task automatic cmd(input logic psh, input logic pp, input logic [7:0] d,
                       input logic ss, input logic op, input logic cl, input logic clr);
        push_in = psh; pop_in = pp; data_in = d;
        skip_start_in = ss; open_in = op; close_in = cl; clear_err_in = clr;
        @(posedge clk);
        #1;
        push_in = 0; pop_in = 0; data_in = 8'h00;
        skip_start_in = 0; open_in = 0; close_in = 0; clear_err_in = 0;
    endtask

    task automatic push(input logic [7:0] d); cmd(1, 0, d, 0, 0, 0, 0); endtask
    task automatic pop();                     cmd(0, 1, 8'h00, 0, 0, 0, 0); endtask
    task automatic idle();                    cmd(0, 0, 8'h00, 0, 0, 0, 0); endtask

    initial begin
        reset_in = 0;
        push_in = 0; pop_in = 0; data_in = 0;
        skip_start_in = 0; open_in = 0; close_in = 0; clear_err_in = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count", count_out, 0);
        chk("rst_empty", empty_out, 1);
        chk("rst_full", full_out, 0);
        chk("rst_data", data_out, 0);
        chk("rst_skipping", skipping_out, 0);
        chk("rst_done", skip_done_out, 0);
        chk("rst_ovf", overflow_out, 0);
        chk("rst_unf", underflow_out, 0);
        @(negedge clk);
        reset_in = 1;

        // Basic push/pop; first edge after reset release takes the command
        push(8'h10);
        chk("p1_count", count_out, 1);
        chk("p1_data", data_out, 8'h10);
        push(8'h20);
        push(8'h30);
        chk("p3_count", count_out, 3);
        chk("p3_data", data_out, 8'h30);
        pop();
        chk("pop_data", data_out, 8'h20);
        chk("pop_count", count_out, 2);
        pop();
        chk("pop2_data", data_out, 8'h10);
        pop();
        chk("pop3_data", data_out, 0);
        chk("pop3_empty", empty_out, 1);
        chk("pop3_unf", underflow_out, 0);

        // Empty-stack errors and replace-on-empty
        pop();
        chk("unf_set", underflow_out, 1);
        chk("unf_count", count_out, 0);
        cmd(1, 1, 8'h07, 0, 0, 0, 0);
        chk("pp_empty_count", count_out, 1);
        chk("pp_empty_data", data_out, 8'h07);
        chk("pp_empty_unf", underflow_out, 1);
        cmd(0, 0, 8'h00, 0, 0, 0, 1);
        chk("clr_unf", underflow_out, 0);
        chk("clr_ovf", overflow_out, 0);
        pop();
        chk("drain0_empty", empty_out, 1);

        // Fill to full, overflow, replace-top while full
        for (int i = 0; i < 16; i++) push(8'h80 + 8'(i));
        chk("full_count", count_out, 16);
        chk("full_flag", full_out, 1);
        chk("full_data", data_out, 8'h8F);
        push(8'hAA);
        chk("ovf_set", overflow_out, 1);
        chk("ovf_count", count_out, 16);
        chk("ovf_data", data_out, 8'h8F);
        cmd(1, 1, 8'h55, 0, 0, 0, 0);
        chk("rep_data", data_out, 8'h55);
        chk("rep_count", count_out, 16);
        chk("rep_ovf", overflow_out, 1);
        chk("rep_unf", underflow_out, 0);
        cmd(1, 0, 8'hAA, 0, 0, 0, 1);
        chk("clr_vs_new_ovf", overflow_out, 1);
        chk("clr_vs_new_data", data_out, 8'h55);
        cmd(0, 0, 8'h00, 0, 0, 0, 1);
        chk("clr_ovf2", overflow_out, 0);
        pop();
        chk("after_rep_pop_data", data_out, 8'h8E);
        chk("after_rep_pop_count", count_out, 15);
        chk("after_rep_pop_full", full_out, 0);
        for (int i = 0; i < 15; i++) pop();
        chk("drain_count", count_out, 0);
        chk("drain_data", data_out, 0);
        chk("drain_unf", underflow_out, 0);

        // Skip nesting; open/close ignored in IDLE
        push(8'h10); push(8'h20); push(8'h30);
        cmd(0, 0, 8'h00, 0, 1, 1, 0);
        cmd(0, 0, 8'h00, 0, 0, 1, 0);
        chk("idle_close_ignored", skipping_out, 0);
        chk("idle_close_done", skip_done_out, 0);
        cmd(1, 0, 8'h99, 1, 0, 0, 0);
        chk("ss_skipping", skipping_out, 1);
        chk("ss_push_ignored", count_out, 3);
        cmd(0, 0, 8'h00, 0, 1, 0, 0);
        chk("o1_skipping", skipping_out, 1);
        cmd(0, 0, 8'h00, 0, 1, 0, 0);
        chk("o2_skipping", skipping_out, 1);
        cmd(0, 0, 8'h00, 0, 0, 1, 0);
        chk("c1_skipping", skipping_out, 1);
        cmd(0, 0, 8'h00, 0, 0, 1, 0);
        chk("c2_skipping", skipping_out, 1);
        chk("c2_done", skip_done_out, 0);
        cmd(0, 0, 8'h00, 0, 0, 1, 0);
        chk("c3_skipping", skipping_out, 0);
        chk("c3_done", skip_done_out, 1);
        idle();
        chk("done_pulse_end", skip_done_out, 0);
        chk("skip_count_kept", count_out, 3);
        chk("skip_data_kept", data_out, 8'h30);

        // SKIP ignores stack commands; open+close together holds depth
        cmd(0, 0, 8'h00, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) cmd(1, (i % 2) == 0, 8'h44, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) cmd(0, 1, 8'h00, 0, 0, 0, 0);
        chk("skp_cmd_count", count_out, 3);
        chk("skp_cmd_data", data_out, 8'h30);
        chk("skp_cmd_ovf", overflow_out, 0);
        chk("skp_cmd_unf", underflow_out, 0);
        cmd(0, 0, 8'h00, 0, 1, 1, 0);
        chk("oc_both_skipping", skipping_out, 1);
        cmd(0, 0, 8'h00, 0, 0, 1, 0);
        chk("oc_exit", skipping_out, 0);
        chk("oc_exit_done", skip_done_out, 1);

        // Skip counter saturation at 255
        cmd(0, 0, 8'h00, 1, 0, 0, 0);
        for (int i = 0; i < 255; i++) cmd(0, 0, 8'h00, 0, 1, 0, 0);
        chk("sat_no_ovf_yet", overflow_out, 0);
        cmd(0, 0, 8'h00, 0, 1, 0, 0);
        chk("sat_ovf", overflow_out, 1);
        chk("sat_skipping", skipping_out, 1);
        for (int i = 0; i < 255; i++) cmd(0, 0, 8'h00, 0, 0, 1, 0);
        chk("sat_still_skip", skipping_out, 1);
        cmd(0, 0, 8'h00, 0, 0, 1, 0);
        chk("sat_exit", skipping_out, 0);
        chk("sat_exit_done", skip_done_out, 1);
        cmd(0, 0, 8'h00, 0, 0, 0, 1);
        chk("sat_clr", overflow_out, 0);

        // Asynchronous reset in the middle of SKIP
        cmd(0, 0, 8'h00, 1, 0, 0, 0);
        cmd(0, 0, 8'h00, 0, 1, 0, 0);
        chk("pre_rst_count", count_out, 3);
        #2;
        reset_in = 0;
        #1;
        chk("arst_skipping", skipping_out, 0);
        chk("arst_count", count_out, 0);
        chk("arst_empty", empty_out, 1);
        chk("arst_data", data_out, 0);
        @(negedge clk);
        reset_in = 1;
        push(8'h42);
        chk("post_rst_count", count_out, 1);
        chk("post_rst_data", data_out, 8'h42);
        chk("post_rst_skipping", skipping_out, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
